i2c_target: RTL and testbench

- I2C target (responder) with a 7-bit address and an 8-bit register-pointer protocol; it is the other end of the SoC's I2C master.
- Used on-chip as a loopback target for bench and bring-up of the master, and as a board-level slave exposing a small register bank.
- Filters and synchronises SCL/SDA, detects START/STOP, shifts bytes and drives ACK/read data open-drain.
- Presents a simple register read/write strobe interface.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_input_filter.sv | 35 +++
 rtl/i2c_target.sv | 199 +++++++++++++++++++
 tb/tb_i2c_target.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

  localparam int unsigned BITCNT_W = 3;

endpackage

// File: rtl/i2c_input_filter.sv
// Two-flop synchroniser followed by a run-length filter; the output only follows
// the pin after FILTER_LEN consecutive samples disagree with the current level.
module i2c_input_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address and 8-bit register pointer; exposes a one-cycle
// register read/write strobe interface and drives SDA through an open-drain enable.
module i2c_target #(
  parameter logic [6:0]  I2C_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  import i2c_pkg::*;

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] rx_byte;

  i2c_state_t          state;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [7:0]          shreg;
  logic                rw;
  logic                load_pend;
  logic                got_ack;

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .reset (reset),
    .pin   (scl_in),
    .level (scl_f)
  );

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .reset (reset),
    .pin   (sda_in),
    .level (sda_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_cond = scl_f & sda_q & ~sda_f;
  assign stop_cond  = scl_f & ~sda_q & sda_f;
  assign rx_byte    = {shreg[6:0], sda_f};

  // shreg doubles as the receive shifter and, in RDATA, holds the not-yet-sent bits at the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= I2C_RW_WRITE;
      load_pend <= 1'b0;
      got_ack   <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      load_pend <= 1'b0;
      if (start_cond) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        got_ack <= 1'b0;
      end else if (stop_cond) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        got_ack <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + BITCNT_W'(1);
            if (bit_cnt == BITCNT_W'(7)) begin
              if (rx_byte[7:1] == I2C_ADDR) begin
                rw    <= rx_byte[0] ? I2C_RW_READ : I2C_RW_WRITE;
                busy  <= 1'b1;
                state <= ST_ADDR_ACK;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + BITCNT_W'(1);
            if (bit_cnt == BITCNT_W'(7)) begin
              reg_addr <= rx_byte;
              state    <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + BITCNT_W'(1);
            if (bit_cnt == BITCNT_W'(7)) begin
              reg_wdata <= rx_byte;
              reg_we    <= 1'b1;
              state     <= ST_WDATA_ACK;
            end
          end
          // ACK slot: first fall starts driving, second fall ends the slot
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= ~ACK;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              if (rw == I2C_RW_READ) begin
                state     <= ST_RDATA;
                reg_re    <= 1'b1;
                load_pend <= 1'b1;
              end else begin
                state <= ST_PTR;
              end
            end
          end
          ST_PTR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= ~ACK;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WDATA;
            end
          end
          ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= ~ACK;
            end else begin
              sda_oe   <= 1'b0;
              bit_cnt  <= '0;
              reg_addr <= reg_addr + 8'd1;
              state    <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (load_pend) begin
              shreg  <= {reg_rdata[6:0], 1'b0};
              sda_oe <= ~reg_rdata[7];
            end else if (scl_fall) begin
              if (bit_cnt == BITCNT_W'(7)) begin
                sda_oe   <= 1'b0;
                bit_cnt  <= '0;
                got_ack  <= 1'b0;
                reg_addr <= reg_addr + 8'd1;
                state    <= ST_RACK;
              end else begin
                sda_oe  <= ~shreg[7];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + BITCNT_W'(1);
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              if (sda_f == NACK) begin
                state <= ST_WAIT_STOP;
              end else begin
                got_ack <= 1'b1;
              end
            end else if (scl_fall && got_ack) begin
              got_ack   <= 1'b0;
              bit_cnt   <= '0;
              reg_re    <= 1'b1;
              load_pend <= 1'b1;
              state     <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master with randomized transactions,
// checked against a pointer/register-bank model kept at transaction level.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int unsigned Q     = 10;
  localparam logic [6:0]  TADDR = 7'h50;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] obs_wq[$];
  logic [15:0] exp_wq[$];
  logic [7:0]  obs_rq[$];
  logic [7:0]  exp_rq[$];
  logic [7:0]  model_ptr;
  logic        model_busy;
  int          glitch_len;
  logic        we_d, re_d;

  always #5 clk = ~clk;

  assign sda_bus   = m_sda & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'hFF;

  i2c_target #(.I2C_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Register-interface monitor: log every strobe and confirm each is a single cycle
  always @(negedge clk) begin
    if (reset) begin
      we_d = 1'b0;
      re_d = 1'b0;
    end else begin
      if (reg_we) begin
        obs_wq.push_back({reg_addr, reg_wdata});
        check("we_one_clk", 32'(we_d), 32'(0));
      end
      if (reg_re) begin
        obs_rq.push_back(reg_addr);
        check("re_one_clk", 32'(re_d), 32'(0));
      end
      we_d = reg_we;
      re_d = reg_re;
    end
  end

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic send_start();
    m_sda = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic send_stop();
    m_sda = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    m_sda = 1'b1; wait_q(2);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q();
    scl = 1'b1;
    if (glitch_len > 0) begin
      repeat (Q / 2) @(negedge clk);
      m_sda = ~b;
      repeat (glitch_len) @(negedge clk);
      m_sda = b;
      repeat (2 * Q - Q / 2 - glitch_len) @(negedge clk);
    end else begin
      wait_q(2);
    end
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack);
  endtask

  task automatic check_logs();
    check("n_writes", 32'(obs_wq.size()), 32'(exp_wq.size()));
    for (int i = 0; i < exp_wq.size() && i < obs_wq.size(); i++)
      check("write_entry", 32'(obs_wq[i]), 32'(exp_wq[i]));
    check("n_reads", 32'(obs_rq.size()), 32'(exp_rq.size()));
    for (int i = 0; i < exp_rq.size() && i < obs_rq.size(); i++)
      check("read_entry", 32'(obs_rq[i]), 32'(exp_rq[i]));
    obs_wq.delete(); exp_wq.delete();
    obs_rq.delete(); exp_rq.delete();
  endtask

  // Write transaction: address, pointer, then n data bytes taken MSB-first from data
  task automatic xfer_write(input logic [6:0] a, input logic [7:0] ptr, input int n,
                            input logic [23:0] data, input logic do_stop);
    logic       ack;
    logic       hit;
    logic [7:0] d;
    hit = (a == TADDR);
    send_start();
    write_byte({a, 1'b0}, ack);
    check("addr_ack", 32'(ack), hit ? 32'(0) : 32'(1));
    model_busy = model_busy | hit;
    check("busy_after_addr", 32'(busy), 32'(model_busy));
    write_byte(ptr, ack);
    check("ptr_ack", 32'(ack), hit ? 32'(0) : 32'(1));
    if (hit) model_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      d = data[23 - 8 * i -: 8];
      write_byte(d, ack);
      check("data_ack", 32'(ack), hit ? 32'(0) : 32'(1));
      if (hit) begin
        exp_wq.push_back({model_ptr, d});
        model_ptr = model_ptr + 8'd1;
      end
    end
    if (do_stop) begin
      send_stop();
      model_busy = 1'b0;
      check("busy_after_stop", 32'(busy), 32'(0));
    end
    check_logs();
  endtask

  // Read transaction from the current pointer; last byte NACKed
  task automatic xfer_read(input int n, input logic do_stop);
    logic       ack;
    logic [7:0] d;
    send_start();
    write_byte({TADDR, 1'b1}, ack);
    check("raddr_ack", 32'(ack), 32'(0));
    model_busy = 1'b1;
    check("busy_read", 32'(busy), 32'(1));
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1) ? 1'b1 : 1'b0);
      check("read_data", 32'(d), 32'(model_ptr ^ 8'hFF));
      exp_rq.push_back(model_ptr);
      model_ptr = model_ptr + 8'd1;
    end
    check("sda_released_after_nack", 32'(sda_oe), 32'(0));
    if (do_stop) begin
      send_stop();
      model_busy = 1'b0;
      check("busy_after_stop", 32'(busy), 32'(0));
    end
    check_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       stopped;
    logic       rs;
    logic [6:0] a;
    logic [7:0] p;
    int         kind, n;

    reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
    glitch_len = 0; model_ptr = 8'h00; model_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_reg_addr", 32'(reg_addr), 32'(0));
    check("rst_reg_wdata", 32'(reg_wdata), 32'(0));
    check("rst_reg_we", 32'(reg_we), 32'(0));
    check("rst_reg_re", 32'(reg_re), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    wait_q(2);

    xfer_write(TADDR, 8'h10, 2, 24'hA53C00, 1'b1);
    xfer_write(TADDR, 8'h20, 0, 24'h0, 1'b0);
    xfer_read(2, 1'b1);
    xfer_write(7'h51, 8'h10, 2, 24'h1234_00, 1'b1);
    xfer_write(TADDR, 8'hFF, 2, 24'h0102_00, 1'b1);
    xfer_write(7'h00, 8'h44, 1, 24'h77_0000, 1'b1);

    // Short SDA glitches while SCL is high must not look like START/STOP
    glitch_len = 1;
    xfer_write(TADDR, 8'h40, 2, 24'hA55A00, 1'b1);
    glitch_len = 2;
    xfer_write(TADDR, 8'h48, 1, 24'hC3_0000, 1'b1);
    glitch_len = 0;

    // Repeated START right after a NACKed read continues from the advanced pointer
    xfer_write(TADDR, 8'h30, 0, 24'h0, 1'b0);
    xfer_read(2, 1'b0);
    xfer_read(1, 1'b1);

    // Async reset while the target drives a 0 read bit
    xfer_write(TADDR, 8'hF0, 0, 24'h0, 1'b0);
    send_start();
    write_byte({TADDR, 1'b1}, ack);
    check("rst_test_addr_ack", 32'(ack), 32'(0));
    exp_rq.push_back(8'hF0);
    check("read_bit7_driven", 32'(sda_oe), 32'(1));
    #2 reset = 1'b1;
    #1 check("async_rst_sda", 32'(sda_oe), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_addr", 32'(reg_addr), 32'(0));
    scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_ptr = 8'h00; model_busy = 1'b0;
    wait_q(2);
    check_logs();
    xfer_read(1, 1'b1);

    stopped = 1'b1;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      rs   = 1'($urandom_range(0, 1));
      p    = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      case (kind)
        0: xfer_write(TADDR, p, n, 24'($urandom), rs);
        1: begin
          xfer_write(TADDR, p, 0, 24'h0, 1'b0);
          xfer_read(n, rs);
        end
        2: xfer_read(n, rs);
        default: begin
          a = 7'($urandom);
          if (a == TADDR) a = 7'h51;
          xfer_write(a, p, n, 24'($urandom), rs);
        end
      endcase
      stopped = rs;
    end
    if (!stopped) begin
      send_stop();
      model_busy = 1'b0;
      check("final_busy", 32'(busy), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
